// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Arbiter sharing one fixed-latency synchronous RAM between the instruction-fetch
// port and the data-memory port, with req/ack handshakes and a pipeline stall.
module mem_port_arbiter #(
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic        stall,
    output logic        ram_en,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_last_dm;
    logic        r_gnt_dm;
    logic        r_we;
    logic        r_if_ack;
    logic        r_dm_ack;
    logic [31:0] r_if_rdata;
    logic [31:0] r_dm_rdata;
    logic        r_ram_en;
    logic        r_ram_we;
    logic [31:0] r_ram_addr;
    logic [31:0] r_ram_wdata;
    logic        w_pick_dm;

    // Grant selection: a lone requester wins; on a tie the port not served last wins.
    always_comb begin
        w_pick_dm = 1'b0;
        if (dm_req && (!if_req || !r_last_dm)) begin
            w_pick_dm = 1'b1;
        end else begin
            w_pick_dm = 1'b0;
        end
    end

    // Access sequencer: grant, issue strobe, latency countdown, one-cycle ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_last_dm   <= 1'b0;
            r_gnt_dm    <= 1'b0;
            r_we        <= 1'b0;
            r_if_ack    <= 1'b0;
            r_dm_ack    <= 1'b0;
            r_if_rdata  <= 32'h0000_0000;
            r_dm_rdata  <= 32'h0000_0000;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= 32'h0000_0000;
            r_ram_wdata <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (if_req || dm_req) begin
                        r_gnt_dm   <= w_pick_dm;
                        r_last_dm  <= w_pick_dm;
                        r_we       <= w_pick_dm & dm_we;
                        r_ram_en   <= 1'b1;
                        r_ram_we   <= w_pick_dm & dm_we;
                        r_ram_addr <= w_pick_dm ? dm_addr : if_addr;
                        // Instruction fetches never write, so the write-data register keeps its value.
                        if (w_pick_dm) begin
                            r_ram_wdata <= dm_wdata;
                        end else begin
                            r_ram_wdata <= r_ram_wdata;
                        end
                        r_state <= ST_ISSUE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    r_ram_en <= 1'b0;
                    r_ram_we <= 1'b0;
                    r_cnt    <= LAT_LOAD;
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_cnt <= 4'd1) begin
                        if (!r_we) begin
                            if (r_gnt_dm) begin
                                r_dm_rdata <= ram_rdata;
                            end else begin
                                r_if_rdata <= ram_rdata;
                            end
                        end else begin
                            r_if_rdata <= r_if_rdata;
                        end
                        r_cnt    <= 4'd0;
                        r_if_ack <= ~r_gnt_dm;
                        r_dm_ack <= r_gnt_dm;
                        r_state  <= ST_DONE;
                    end else begin
                        r_cnt   <= r_cnt - 4'd1;
                        r_state <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    r_if_ack <= 1'b0;
                    r_dm_ack <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_if_ack <= 1'b0;
                    r_dm_ack <= 1'b0;
                    r_ram_en <= 1'b0;
                    r_ram_we <= 1'b0;
                    r_cnt    <= 4'd0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_ack    = r_if_ack;
    assign dm_ack    = r_dm_ack;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    // Stall drops in the ack cycle itself so the pipeline advances with the data.
    assign stall     = (if_req & ~r_if_ack) | (dm_req & ~r_dm_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_port_arbiter: a LATENCY=2 instance checked every cycle against a
// timeline model, plus LATENCY=1 and LATENCY=15 instances for single-read timing.
module tb_mem_port_arbiter;

    localparam int NI   = 3;
    localparam int MLAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req    [NI];
    logic [31:0] if_addr   [NI];
    logic        dm_req    [NI];
    logic        dm_we     [NI];
    logic [31:0] dm_addr   [NI];
    logic [31:0] dm_wdata  [NI];
    logic [31:0] if_rdata  [NI];
    logic [31:0] dm_rdata  [NI];
    logic        if_ack    [NI];
    logic        dm_ack    [NI];
    logic        stall     [NI];
    logic        ram_en    [NI];
    logic        ram_we    [NI];
    logic [31:0] ram_addr  [NI];
    logic [31:0] ram_wdata [NI];
    logic [31:0] ram_rdata [NI];

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;
    logic ord_q[$];

    bit          wvalid [256];
    logic [31:0] wmem   [256];

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_read(input logic [31:0] a);
        if (wvalid[a[9:2]]) return wmem[a[9:2]];
        else if (a == 32'h0000_0040) return 32'h8C01_0004;
        else return {a[15:0], ~a[15:0]};
    endfunction

    // RAM write port of the main instance only
    always @(posedge clk) begin
        if (ram_en[0] && ram_we[0]) begin
            wmem[ram_addr[0][9:2]]   <= ram_wdata[0];
            wvalid[ram_addr[0][9:2]] <= 1'b1;
        end
    end

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int unsigned L_G = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
        int          cd;
        logic [31:0] ra;

        mem_port_arbiter #(.LATENCY(L_G)) u_dut (
            .clk(clk), .rst(rst),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_rdata(if_rdata[g]), .if_ack(if_ack[g]),
            .dm_req(dm_req[g]), .dm_we(dm_we[g]), .dm_addr(dm_addr[g]), .dm_wdata(dm_wdata[g]),
            .dm_rdata(dm_rdata[g]), .dm_ack(dm_ack[g]), .stall(stall[g]),
            .ram_en(ram_en[g]), .ram_we(ram_we[g]), .ram_addr(ram_addr[g]),
            .ram_wdata(ram_wdata[g]), .ram_rdata(ram_rdata[g])
        );

        // Read data is valid only in the cycle exactly L_G cycles after the strobe
        always @(posedge clk) begin
            if (ram_en[g] && !ram_we[g]) begin
                cd <= int'(L_G);
                ra <= ram_addr[g];
            end else if (cd > 0) begin
                cd <= cd - 1;
            end
        end
        assign ram_rdata[g] = (cd == 1) ? ram_read(ra) : (32'hBAD0_0000 + 32'(cd));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: t counts cycles since grant (0 = idle, 1 = issue, MLAT+2 = ack)
    int          m_t;
    logic        m_last_dm, m_gnt_dm, m_we;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
    logic        m_dm_wins;

    always_comb begin
        if (if_req[0] && dm_req[0]) m_dm_wins = ~m_last_dm;
        else                        m_dm_wins = dm_req[0];
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t <= 0; m_last_dm <= 1'b0; m_gnt_dm <= 1'b0; m_we <= 1'b0;
            m_addr <= 32'h0; m_wdata <= 32'h0; m_if_rdata <= 32'h0; m_dm_rdata <= 32'h0;
        end else if (m_t == 0) begin
            if (if_req[0] || dm_req[0]) begin
                m_t       <= 1;
                m_gnt_dm  <= m_dm_wins;
                m_last_dm <= m_dm_wins;
                m_we      <= m_dm_wins && dm_we[0];
                m_addr    <= m_dm_wins ? dm_addr[0] : if_addr[0];
                if (m_dm_wins) m_wdata <= dm_wdata[0];
            end
        end else if (m_t == MLAT + 1) begin
            if (!m_we && m_gnt_dm)  m_dm_rdata <= ram_rdata[0];
            if (!m_we && !m_gnt_dm) m_if_rdata <= ram_rdata[0];
            m_t <= m_t + 1;
        end else if (m_t == MLAT + 2) begin
            m_t <= 0;
        end else begin
            m_t <= m_t + 1;
        end
    end

    // Per-cycle comparison of the main instance against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            logic e_if_ack, e_dm_ack;
            e_if_ack = (m_t == MLAT + 2) && !m_gnt_dm;
            e_dm_ack = (m_t == MLAT + 2) && m_gnt_dm;
            chk("ram_en", 32'(ram_en[0]), 32'(m_t == 1));
            chk("ram_we", 32'(ram_we[0]), 32'((m_t == 1) && m_we));
            chk("ram_addr", ram_addr[0], m_addr);
            if ((m_t == 1) && m_we) chk("ram_wdata", ram_wdata[0], m_wdata);
            chk("if_ack", 32'(if_ack[0]), 32'(e_if_ack));
            chk("dm_ack", 32'(dm_ack[0]), 32'(e_dm_ack));
            chk("if_rdata", if_rdata[0], m_if_rdata);
            chk("dm_rdata", dm_rdata[0], m_dm_rdata);
            chk("stall", 32'(stall[0]), 32'((if_req[0] && !e_if_ack) || (dm_req[0] && !e_dm_ack)));
            if (dm_ack[0]) ord_q.push_back(1'b1);
            else if (if_ack[0]) ord_q.push_back(1'b0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_ack(input bit is_dm, input int budget, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (((is_dm ? dm_ack[0] : if_ack[0]) !== 1'b1) && (cyc < budget));
        if ((is_dm ? dm_ack[0] : if_ack[0]) !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_ack_%s: no ack within %0d cycles", is_dm ? "dm" : "if", budget);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        logic [5:0] exp_ord;
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            if_req[k] = 1'b0; if_addr[k] = 32'h0; dm_req[k] = 1'b0;
            dm_we[k] = 1'b0; dm_addr[k] = 32'h0; dm_wdata[k] = 32'h0;
        end
        step();
        step();
        cmp_en = 1'b1;
        chk("rst_ram_en", 32'(ram_en[0]), 32'h0);
        chk("rst_ram_addr", ram_addr[0], 32'h0);
        chk("rst_ram_wdata", ram_wdata[0], 32'h0);
        chk("rst_if_rdata", if_rdata[0], 32'h0);
        chk("rst_dm_rdata", dm_rdata[0], 32'h0);
        rst = 1'b0;

        // single instruction read
        if_req[0] = 1'b1; if_addr[0] = 32'h0000_0040;
        step();
        chk("rd_issue_en", 32'(ram_en[0]), 32'h1);
        chk("rd_issue_addr", ram_addr[0], 32'h0000_0040);
        if_addr[0] = 32'h7777_0000;
        step(); step(); step();
        chk("rd_ack", 32'(if_ack[0]), 32'h1);
        chk("rd_data", if_rdata[0], 32'h8C01_0004);
        chk("rd_dm_untouched", dm_rdata[0], 32'h0);
        if_req[0] = 1'b0;
        step();
        chk("rd_ack_pulse", 32'(if_ack[0]), 32'h0);
        chk("rd_data_held", if_rdata[0], 32'h8C01_0004);

        // data write
        dm_req[0] = 1'b1; dm_we[0] = 1'b1; dm_addr[0] = 32'h0000_0100; dm_wdata[0] = 32'hDEAD_BEEF;
        step();
        chk("wr_en", 32'(ram_en[0]), 32'h1);
        chk("wr_we", 32'(ram_we[0]), 32'h1);
        chk("wr_addr", ram_addr[0], 32'h0000_0100);
        chk("wr_wdata", ram_wdata[0], 32'hDEAD_BEEF);
        dm_wdata[0] = 32'h0BAD_F00D;
        step();
        chk("wr_en_off", 32'(ram_en[0]), 32'h0);
        chk("wr_we_off", 32'(ram_we[0]), 32'h0);
        step(); step();
        chk("wr_ack", 32'(dm_ack[0]), 32'h1);
        chk("wr_dm_rdata", dm_rdata[0], 32'h0);
        dm_req[0] = 1'b0; dm_we[0] = 1'b0;
        step();

        // simultaneous requests right after reset: data first
        do_reset();
        if_req[0] = 1'b1; if_addr[0] = 32'h0000_0048;
        dm_req[0] = 1'b1; dm_addr[0] = 32'h0000_0100;
        #1;
        chk("tie_stall_c0", 32'(stall[0]), 32'h1);
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c <= 8) chk($sformatf("tie_stall_c%0d", c), 32'(stall[0]), 32'h1);
            if (c == 4) begin
                chk("tie_dm_ack", 32'(dm_ack[0]), 32'h1);
                chk("tie_dm_rdata", dm_rdata[0], 32'hDEAD_BEEF);
                dm_req[0] = 1'b0;
            end
            if (c == 6) chk("tie_if_issue", ram_addr[0], 32'h0000_0048);
            if (c == 9) begin
                chk("tie_if_ack", 32'(if_ack[0]), 32'h1);
                chk("tie_if_rdata", if_rdata[0], 32'h0048_FFB7);
                if_req[0] = 1'b0;
            end
        end
        step();

        // sustained contention: three accesses per port, re-requested on each ack
        do_reset();
        ord_q.delete();
        fork
            begin
                int cd_cyc;
                for (int k = 0; k < 3; k++) begin
                    dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 32'h0000_0200 + 32'(k * 4);
                    wait_ack(1'b1, 40, cd_cyc);
                end
                dm_req[0] = 1'b0;
            end
            begin
                int ci_cyc;
                for (int k = 0; k < 3; k++) begin
                    if_req[0] = 1'b1; if_addr[0] = 32'h0000_0300 + 32'(k * 4);
                    wait_ack(1'b0, 40, ci_cyc);
                end
                if_req[0] = 1'b0;
            end
        join
        step();
        exp_ord = 6'b010101;
        chk("order_len", 32'(ord_q.size()), 32'd6);
        for (int k = 0; k < 6 && k < ord_q.size(); k++)
            chk($sformatf("order_%0d", k), 32'(ord_q[k]), 32'(exp_ord[k]));

        // reset during WAIT of an instruction read
        if_req[0] = 1'b1; if_addr[0] = 32'h0000_0040;
        step(); step();
        chk("pre_rst_if_rdata", if_rdata[0], 32'h0308_FCF7);
        #1 rst = 1'b1;
        #1;
        chk("rstw_ram_en", 32'(ram_en[0]), 32'h0);
        chk("rstw_if_ack", 32'(if_ack[0]), 32'h0);
        chk("rstw_dm_ack", 32'(dm_ack[0]), 32'h0);
        chk("rstw_if_rdata", if_rdata[0], 32'h0);
        chk("rstw_dm_rdata", dm_rdata[0], 32'h0);
        dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 32'h0000_0100;
        step();
        rst = 1'b0;
        wait_ack(1'b1, 20, cyc);
        chk("retry_dm_cycle", 32'(cyc), 32'd4);
        chk("retry_dm_rdata", dm_rdata[0], 32'hDEAD_BEEF);
        dm_req[0] = 1'b0;
        wait_ack(1'b0, 20, cyc);
        chk("retry_if_cycle", 32'(cyc), 32'd5);
        chk("retry_if_rdata", if_rdata[0], 32'h8C01_0004);
        if_req[0] = 1'b0;
        step();

        // LATENCY=1 and LATENCY=15 instances
        for (int k = 1; k < NI; k++) begin
            if_req[k] = 1'b1; if_addr[k] = 32'h0000_0040;
            cyc = 0;
            do begin
                step();
                cyc++;
            end while ((if_ack[k] !== 1'b1) && (cyc < 40));
            chk($sformatf("lat_inst%0d_ack_cycle", k), 32'(cyc), (k == 1) ? 32'd3 : 32'd17);
            chk($sformatf("lat_inst%0d_rdata", k), if_rdata[k], 32'h8C01_0004);
            if_req[k] = 1'b0;
            step();
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
